// File: rtl/seg_pkg.sv
// Shared seven-segment constants and the nibble-to-pattern table.
// All patterns are active-low, bit order gfedcba (bit6 = g).
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    // Entry n is the pattern for hex digit n; listed F down to 0.
    localparam logic [15:0][6:0] HEX_PAT = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0011000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] hex_to_pattern(input logic [3:0] nibble);
        return HEX_PAT[nibble];
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble -> active-low segment pattern, forced dark when blank=1.
// Zero latency; no flow control.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] pattern
);

    assign pattern = blank ? SEG_BLANK : hex_to_pattern(nibble);

endmodule

// File: rtl/hex_display_scan.sv
// Latches a 32-bit word and scans it onto an 8-digit active-low seven-segment bank.
// Outputs are registered one cycle behind the scan index; capture has no backpressure.
module hex_display_scan
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           word_in,
    input  logic                  word_valid,
    input  logic                  freeze,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] anode,
    output logic                  digit_tick,
    output logic [31:0]           shown_word
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [31:0]           word_q, word_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]            seg_q, seg_d;
    logic                  tick_q, tick_d;

    logic                  slot_end;
    logic [3:0]            nibble;
    logic [31:0]           upper;
    logic                  blank_digit;

    always_comb begin
        slot_end = (cnt_q == CNT_MAX);
        cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d    = slot_end ? idx_q + 3'd1 : idx_q;
        tick_d   = slot_end;
        word_d   = (word_valid && !freeze) ? word_in : word_q;
    end

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        nibble      = word_q[{idx_q, 2'b00} +: 4];
        upper       = word_q >> {idx_q, 2'b00};
        blank_digit = blank_lz && (idx_q != 3'd0) && (upper == 32'd0);
        anode_d     = blank_digit ? ANODE_OFF : ~(8'd1 << idx_q);
    end

    seg_hex_decoder u_dec (
        .nibble  (nibble),
        .blank   (blank_digit),
        .pattern (seg_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            word_q  <= 32'd0;
            anode_q <= ANODE_OFF;
            seg_q   <= SEG_BLANK;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign anode      = anode_q;
    assign digit_tick = tick_q;
    assign shown_word = word_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan: directed scenario tasks plus a cycle model feeding a scoreboard.
module tb_hex_display_scan;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] word_in = 32'd0;
    logic        word_valid = 1'b0;
    logic        freeze = 1'b0;
    logic        blank_lz = 1'b0;

    logic [6:0]  seg4, seg1;
    logic [7:0]  anode4, anode1;
    logic        tick4, tick1;
    logic [31:0] shown4, shown1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hex_display_scan #(.REFRESH_DIV(DIV)) dut (
        .clock(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
        .freeze(freeze), .blank_lz(blank_lz), .seg(seg4), .anode(anode4),
        .digit_tick(tick4), .shown_word(shown4)
    );

    hex_display_scan #(.REFRESH_DIV(1)) dut1 (
        .clock(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
        .freeze(freeze), .blank_lz(blank_lz), .seg(seg1), .anode(anode1),
        .digit_tick(tick1), .shown_word(shown1)
    );

    // ---------------- reference model + scoreboard (REFRESH_DIV=4 instance) ----------------
    typedef struct packed {
        logic [7:0]  an;
        logic [6:0]  sg;
        logic        tk;
        logic [31:0] sw;
    } exp_t;

    exp_t        sb_q[$];
    logic [6:0]  pat_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    bit          sb_on = 0;
    int          m_cnt = 0;
    int          m_idx = 0;
    logic [31:0] m_shown = 32'd0;

    always @(posedge clk) begin
        exp_t e;
        bit   lz;
        bit   blank;
        if (reset) sb_on = 1;
        if (sb_on) begin
            if (reset) begin
                e = '{an: 8'hFF, sg: 7'h7F, tk: 1'b0, sw: 32'd0};
                m_cnt = 0; m_idx = 0; m_shown = 32'd0;
            end else begin
                lz = 1;
                for (int k = 0; k < 8; k++)
                    if (k >= m_idx && m_shown[4*k +: 4] != 4'd0) lz = 0;
                blank = blank_lz && (m_idx != 0) && lz;
                e.an = blank ? 8'hFF : ~(8'd1 << m_idx);
                e.sg = blank ? 7'h7F : pat_tbl[m_shown[4*m_idx +: 4]];
                e.tk = (m_cnt == DIV - 1);
                if (word_valid && !freeze) m_shown = word_in;
                e.sw = m_shown;
                if (m_cnt == DIV - 1) begin
                    m_cnt = 0;
                    m_idx = (m_idx + 1) % 8;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            sb_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if ({anode4, seg4, tick4, shown4} !== e) begin
                bad++;
                $display("FAIL scoreboard t=%0t got an=%h seg=%b tick=%b word=%h exp an=%h seg=%b tick=%b word=%h",
                         $time, anode4, seg4, tick4, shown4, e.an, e.sg, e.tk, e.sw);
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (anode4 !== 8'hFF || seg4 !== 7'h7F || shown4 !== 32'd0 || tick4 !== 1'b0) begin
                bad++;
                $display("FAIL reset_state got an=%h seg=%b word=%h tick=%b", anode4, seg4, shown4, tick4);
            end
        end
        reset = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            step();
            total++;
            if (tick4 !== (n == 4)) begin
                bad++;
                $display("FAIL first_tick edge=%0d got tick=%b exp %b", n, tick4, (n == 4));
            end
            if (n == 5) begin
                total++;
                if (anode4 !== 8'hFD) begin
                    bad++;
                    $display("FAIL first_advance got an=%h exp FD", anode4);
                end
            end
        end
    endtask

    task automatic test_capture();
        int k;
        word_in = 32'h1234ABCD;
        word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        total++;
        if (shown4 !== 32'h1234ABCD) begin
            bad++;
            $display("FAIL capture got %h exp 1234ABCD", shown4);
        end
        step();
        k = 0;
        while (anode4 !== 8'hFE && k < 64) begin step(); k++; end
        total++;
        if (k >= 64 || seg4 !== 7'b0100001) begin
            bad++;
            $display("FAIL slot0_d got an=%h seg=%b exp an=FE seg=0100001", anode4, seg4);
        end
        k = 0;
        while (anode4 !== 8'h7F && k < 64) begin step(); k++; end
        total++;
        if (k >= 64 || seg4 !== 7'b1111001) begin
            bad++;
            $display("FAIL slot7_1 got an=%h seg=%b exp an=7F seg=1111001", anode4, seg4);
        end
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        word_in = 32'hFFFFFFFF;
        word_valid = 1'b1;
        step();
        total++;
        if (shown4 !== 32'h1234ABCD) begin
            bad++;
            $display("FAIL freeze_hold got %h exp 1234ABCD", shown4);
        end
        freeze = 1'b0;
        step();
        total++;
        if (shown4 !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL unfreeze_capture got %h exp FFFFFFFF", shown4);
        end
        word_in = 32'h11111111;
        step();
        word_in = 32'h22222222;
        step();
        word_valid = 1'b0;
        total++;
        if (shown4 !== 32'h22222222) begin
            bad++;
            $display("FAIL held_valid_recapture got %h exp 22222222", shown4);
        end
    endtask

    task automatic test_blank();
        bit seen0, seen1, seen_off, ok;
        blank_lz = 1'b1;
        word_in = 32'h000000A5;
        word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        step();
        seen0 = 0; seen1 = 0; seen_off = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            ok = (anode4 === 8'hFE && seg4 === 7'b0010010) ||
                 (anode4 === 8'hFD && seg4 === 7'b0001000) ||
                 (anode4 === 8'hFF && seg4 === 7'h7F);
            if (anode4 === 8'hFE) seen0 = 1;
            if (anode4 === 8'hFD) seen1 = 1;
            if (anode4 === 8'hFF) seen_off = 1;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL blank_a5 got an=%h seg=%b", anode4, seg4);
            end
        end
        total++;
        if (!(seen0 && seen1 && seen_off)) begin
            bad++;
            $display("FAIL blank_a5_cover got d0=%0d d1=%0d off=%0d exp all 1", seen0, seen1, seen_off);
        end
        word_in = 32'd0;
        word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        step();
        seen0 = 0; seen_off = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            ok = (anode4 === 8'hFE && seg4 === 7'b1000000) ||
                 (anode4 === 8'hFF && seg4 === 7'h7F);
            if (anode4 === 8'hFE) seen0 = 1;
            if (anode4 === 8'hFF) seen_off = 1;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL blank_zero got an=%h seg=%b", anode4, seg4);
            end
        end
        total++;
        if (!(seen0 && seen_off)) begin
            bad++;
            $display("FAIL blank_zero_cover got d0=%0d off=%0d exp both 1", seen0, seen_off);
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        int prev, idx, k;
        bit wrapped;
        prev = -1;
        wrapped = 0;
        word_in = 32'h89ABCDEF;
        word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        for (int s = 0; s < 9; s++) begin
            k = 0;
            while (tick4 !== 1'b1 && k < 16) begin step(); k++; end
            if (s > 0) begin
                total++;
                if (k !== DIV - 1) begin
                    bad++;
                    $display("FAIL tick_spacing got %0d cycles exp %0d", k, DIV - 1);
                end
            end
            step();
            idx = -1;
            for (int b = 0; b < 8; b++)
                if (anode4 === ~(8'd1 << b)) idx = b;
            if (prev >= 0) begin
                total++;
                if (idx != (prev + 1) % 8) begin
                    bad++;
                    $display("FAIL scan_order got idx=%0d exp %0d", idx, (prev + 1) % 8);
                end
                if (prev == 7 && idx == 0) wrapped = 1;
            end
            prev = idx;
        end
        total++;
        if (!wrapped) begin
            bad++;
            $display("FAIL wrap_7_to_0 got none exp one");
        end
        k = 0;
        while (anode4 !== 8'hDF && k < 64) begin step(); k++; end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (k >= 64 || anode4 !== 8'hFF || seg4 !== 7'h7F || shown4 !== 32'd0 || tick4 !== 1'b0) begin
            bad++;
            $display("FAIL midscan_reset got an=%h seg=%b word=%h tick=%b", anode4, seg4, shown4, tick4);
        end
        for (int n = 1; n <= 4; n++) begin
            step();
            total++;
            if (anode4 !== 8'hFE || tick4 !== (n == 4)) begin
                bad++;
                $display("FAIL restart_idx0 edge=%0d got an=%h tick=%b exp an=FE tick=%b",
                         n, anode4, tick4, (n == 4));
            end
        end
    endtask

    task automatic test_div1();
        logic [7:0] exp_an;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            step();
            exp_an = ~(8'd1 << ((n - 1) % 8));
            total++;
            if (tick1 !== 1'b1 || anode1 !== exp_an) begin
                bad++;
                $display("FAIL div1_walk edge=%0d got an=%h tick=%b exp an=%h tick=1",
                         n, anode1, tick1, exp_an);
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_freeze();
        test_blank();
        test_wrap_and_reset();
        test_div1();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
